if_prefetch: RTL

- Instruction-fetch front end between the Sirius core's decode stage and the instruction ROM.
- Owns the fetch PC and drives the ROM read port (combinational ROM, same-cycle data).
- Buffers fetched {pc, inst} pairs in a small FIFO so decode stalls do not stop fetch.
- Accepts branch redirects from the core and flushes stale prefetched instructions.

---
 rtl/if_prefetch_if.sv | 26 ++
 rtl/if_prefetch.sv | 73 +++++++
 2 files changed

// File: rtl/if_prefetch_if.sv
// Fetch-unit bus bundle: ROM read port, branch redirect and the decode-facing head port.
// The master modport is the prefetch unit; slave is the ROM/core side.
interface if_prefetch_if #(
    parameter int PTR_W = 2
);
    logic             rom_ce_o;
    logic [31:0]      rom_addr_o;
    logic [31:0]      rom_data_i;
    logic             branch_flag_i;
    logic [31:0]      branch_target_i;
    logic             inst_valid_o;
    logic [31:0]      inst_o;
    logic [31:0]      inst_pc_o;
    logic             inst_ready_i;
    logic [PTR_W:0]   fifo_count_o;

    modport master (
        output rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o, fifo_count_o,
        input  rom_data_i, branch_flag_i, branch_target_i, inst_ready_i
    );

    modport slave (
        input  rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o, fifo_count_o,
        output rom_data_i, branch_flag_i, branch_target_i, inst_ready_i
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch: owns the fetch PC, reads a same-cycle ROM and queues {pc, inst}
// pairs in a small FIFO so decode stalls do not stall fetch; branch redirects flush it.
module if_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic         clk,
    input  logic         rst,
    if_prefetch_if.master bus
);
    logic [31:0]    fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0] count;
    logic           rom_ce;
    logic [31:0]    mem_pc   [DEPTH];
    logic [31:0]    mem_inst [DEPTH];

    logic full;
    logic pop;
    logic push;

    assign full = (count == (PTR_W+1)'(DEPTH));
    assign pop  = (count != '0) & bus.inst_ready_i;
    // Full FIFO may still accept a push when the head leaves in the same cycle.
    assign push = rom_ce & ~bus.branch_flag_i & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rom_ce   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else begin
            rom_ce <= 1'b1;
            if (bus.branch_flag_i) begin
                // Redirect wins: drop queued entries and this cycle's ROM word.
                fetch_pc <= {bus.branch_target_i[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    mem_pc[wr_ptr]   <= fetch_pc;
                    mem_inst[wr_ptr] <= bus.rom_data_i;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                    fetch_pc         <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + (PTR_W+1)'(1);
                end else if (pop && !push) begin
                    count <= count - (PTR_W+1)'(1);
                end
            end
        end
    end

    assign bus.rom_ce_o     = rom_ce;
    assign bus.rom_addr_o   = fetch_pc;
    assign bus.inst_valid_o = (count != '0);
    assign bus.inst_o       = mem_inst[rd_ptr];
    assign bus.inst_pc_o    = mem_pc[rd_ptr];
    assign bus.fifo_count_o = count;
endmodule
